// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction/PC words, opcode field positions and the fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned INSTR_BITS = 16;
  localparam int unsigned PC_BITS    = 8;

  typedef logic [INSTR_BITS-1:0] instr_t;
  typedef logic [PC_BITS-1:0]    pc_t;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;

  localparam instr_t NOP = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; flush has priority over push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wrData,
  output logic [WIDTH-1:0]             rdData,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             full;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop & ~empty;
  // A full FIFO accepts a push when the head leaves in the same cycle.
  assign doPush = push & (~full | doPop);
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem req/ack handshake, prefetch FIFO and branch redirect.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W       = 8,
  parameter int unsigned     INSTR_W    = 16,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  input  logic               stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
  localparam int unsigned EW = PC_W + INSTR_W;

  fetch_state_e     state;
  fetch_state_e     nextState;
  logic [PC_W-1:0]  fetchPc;
  logic [PC_W-1:0]  heldAddr;
  logic [CW-1:0]    fifoCount;
  logic [CW-1:0]    countAfterPop;
  logic             fifoEmpty;
  logic [EW-1:0]    headEntry;
  logic             pop;
  logic             push;
  logic             space;
  logic             accepted;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (br_taken),
    .wrData ({fetchPc, imem_rdata}),
    .rdData (headEntry),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  assign pop           = ~fifoEmpty & ~stall;
  assign countAfterPop = fifoCount - CW'(pop);
  assign space         = (countAfterPop < CW'(FIFO_DEPTH));

  // heldAddr tracks the address on the bus so DROP can keep it stable after fetchPc is redirected.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetchPc  <= RESET_PC;
      heldAddr <= '0;
    end else begin
      state    <= nextState;
      heldAddr <= imem_addr;
      if (br_taken)  fetchPc <= br_target;
      else if (push) fetchPc <= fetchPc + 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    if (br_taken) begin
      nextState = (imem_req && !imem_ack) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE:    nextState = (imem_req && !imem_ack) ? WAIT : IDLE;
        WAIT:    nextState = imem_ack ? IDLE : WAIT;
        DROP:    nextState = imem_ack ? IDLE : DROP;
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    case (state)
      IDLE:       imem_req = space & ~br_taken & ~reset;
      WAIT, DROP: imem_req = ~reset;
      default:    imem_req = 1'b0;
    endcase
    imem_addr   = (state == DROP) ? heldAddr : fetchPc;
    accepted    = imem_req & imem_ack;
    push        = accepted & (state != DROP) & ~br_taken;
    instr_valid = ~fifoEmpty;
    instr       = fifoEmpty ? INSTR_W'(NOP) : headEntry[INSTR_W-1:0];
    instr_pc    = fifoEmpty ? '0 : headEntry[EW-1:INSTR_W];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/full, redirect, PC wrap and reset mid-request.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA, reqA, ackA, brTaken, stall, validA;
  logic [7:0]  addrA, brTarget, pcA;
  logic [15:0] rdataA, instrA;

  logic        rstB, reqB, ackB, validB;
  logic        brB, stallB;
  logic [7:0]  addrB, targetB, pcB;
  logic [15:0] rdataB, instrB;

  int unsigned lat;
  int unsigned waitCnt;
  logic        forceAck;
  int          passed = 0;
  int          total  = 0;

  fetch_stage #(.PC_W(8), .INSTR_W(16), .FIFO_DEPTH(2), .RESET_PC(8'h00)) dutA (
    .clk(clk), .reset(rstA), .imem_req(reqA), .imem_addr(addrA), .imem_ack(ackA),
    .imem_rdata(rdataA), .br_taken(brTaken), .br_target(brTarget), .stall(stall),
    .instr_valid(validA), .instr(instrA), .instr_pc(pcA));

  fetch_stage #(.PC_W(8), .INSTR_W(16), .FIFO_DEPTH(2), .RESET_PC(8'hFE)) dutB (
    .clk(clk), .reset(rstB), .imem_req(reqB), .imem_addr(addrB), .imem_ack(ackB),
    .imem_rdata(rdataB), .br_taken(brB), .br_target(targetB), .stall(stallB),
    .instr_valid(validB), .instr(instrB), .instr_pc(pcB));

  // imem model A: mem[a] = a + 0x1000, ack after 'lat' waiting cycles; forceAck injects a stray ack.
  always @(posedge clk) begin
    if (rstA || (reqA && ackA)) waitCnt <= 0;
    else if (reqA)              waitCnt <= waitCnt + 1;
  end
  always_comb begin
    ackA   = forceAck | (reqA && (waitCnt >= lat));
    rdataA = forceAck ? 16'hDEAD : 16'h1000 + {8'h00, addrA};
  end
  assign ackB   = reqB;
  assign rdataB = 16'h1000 + {8'h00, addrB};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetA(input string tag);
    brTaken  = 1'b0;
    forceAck = 1'b0;
    rstA     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, " rst valid"}, {31'b0, validA}, 32'd0);
    check({tag, " rst req"},   {31'b0, reqA},   32'd0);
    check({tag, " rst instr"}, {16'b0, instrA}, 32'h0000);
    check({tag, " rst pc"},    {24'b0, pcA},    32'h00);
    rstA = 1'b0;
  endtask

  task automatic waitValidA(input string name, input int budget);
    for (int k = 0; k < budget && !validA; k++) nextCycle();
    check({name, " valid within budget"}, {31'b0, validA}, 32'd1);
  endtask

  typedef struct {
    logic        stall;
    logic        expValid;
    logic [7:0]  expPc;
    logic [15:0] expInstr;
    logic        expReq;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] wrapPcs[4];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 16'h1000, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h01, 16'h1001, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h02, 16'h1002, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'h03, 16'h1003, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h03, 16'h1003, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h03, 16'h1003, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h03, 16'h1003, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'h03, 16'h1003, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h03, 16'h1003, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'h04, 16'h1004, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h05, 16'h1005, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 8'h06, 16'h1006, 1'b1};
    wrapPcs  = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    rstA = 1'b1; rstB = 1'b1; brTaken = 1'b0; brTarget = '0; stall = 1'b0;
    brB = 1'b0; targetB = '0; stallB = 1'b0; lat = 0; forceAck = 1'b0;

    // Streaming with 0-wait imem, then a 5-cycle stall that fills the FIFO and releases.
    lat = 0; stall = 1'b0;
    resetA("t1");
    for (int i = 0; i < 12; i++) begin
      nextCycle();
      stall = vecs[i].stall;
      #1;
      check($sformatf("t12 valid[%0d]", i), {31'b0, validA}, {31'b0, vecs[i].expValid});
      check($sformatf("t12 pc[%0d]", i),    {24'b0, pcA},    {24'b0, vecs[i].expPc});
      check($sformatf("t12 instr[%0d]", i), {16'b0, instrA}, {16'b0, vecs[i].expInstr});
      check($sformatf("t12 req[%0d]", i),   {31'b0, reqA},   {31'b0, vecs[i].expReq});
    end

    // Redirect while a 3-cycle imem request is outstanding.
    lat = 3; stall = 1'b0;
    resetA("t3");
    nextCycle();
    brTaken = 1'b1; brTarget = 8'h40;
    #1;
    check("t3 req before redirect", {24'b0, addrA}, 32'h00);
    nextCycle();
    brTaken = 1'b0;
    #1;
    check("t3 drop valid", {31'b0, validA}, 32'd0);
    check("t3 drop req",   {31'b0, reqA},   32'd1);
    check("t3 drop addr",  {24'b0, addrA},  32'h00);
    nextCycle();
    check("t3 drop addr held", {24'b0, addrA}, 32'h00);
    nextCycle();
    check("t3 new req",  {31'b0, reqA},  32'd1);
    check("t3 new addr", {24'b0, addrA}, 32'h40);
    check("t3 valid before data", {31'b0, validA}, 32'd0);
    waitValidA("t3", 10);
    check("t3 first pc",    {24'b0, pcA},    32'h40);
    check("t3 first instr", {16'b0, instrA}, 32'h1040);

    // Redirect coincident with an ack while stalled on a non-empty FIFO.
    lat = 1; stall = 1'b1;
    resetA("t4");
    nextCycle();
    nextCycle();
    check("t4 head pc",  {24'b0, pcA},   32'h00);
    check("t4 req addr", {24'b0, addrA}, 32'h01);
    nextCycle();
    brTaken = 1'b1; brTarget = 8'h20;
    #1;
    check("t4 ack with redirect", {31'b0, ackA}, 32'd1);
    check("t4 valid held", {31'b0, validA}, 32'd1);
    nextCycle();
    brTaken = 1'b0;
    #1;
    check("t4 flushed valid", {31'b0, validA}, 32'd0);
    check("t4 flushed instr", {16'b0, instrA}, 32'h0000);
    check("t4 new addr",      {24'b0, addrA},  32'h20);
    waitValidA("t4", 10);
    check("t4 first pc",    {24'b0, pcA},    32'h20);
    check("t4 first instr", {16'b0, instrA}, 32'h1020);

    // PC wrap from RESET_PC = 0xFE.
    check("t5 rst req", {31'b0, reqB}, 32'd0);
    check("t5 rst valid", {31'b0, validB}, 32'd0);
    rstB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      check($sformatf("t5 pc[%0d]", i),    {24'b0, pcB},    {24'b0, wrapPcs[i]});
      check($sformatf("t5 instr[%0d]", i), {16'b0, instrB}, 32'h1000 + {24'b0, wrapPcs[i]});
    end

    // Reset while a request is outstanding, with a stray ack during reset.
    lat = 1; stall = 1'b1;
    resetA("t6");
    nextCycle();
    nextCycle();
    check("t6 pre valid", {31'b0, validA}, 32'd1);
    check("t6 pre req",   {31'b0, reqA},   32'd1);
    rstA = 1'b1;
    nextCycle();
    forceAck = 1'b1;
    #1;
    check("t6 rst valid", {31'b0, validA}, 32'd0);
    check("t6 rst req",   {31'b0, reqA},   32'd0);
    nextCycle();
    forceAck = 1'b0; lat = 0; stall = 1'b0; rstA = 1'b0;
    #1;
    check("t6 post rst valid", {31'b0, validA}, 32'd0);
    check("t6 restart addr",   {24'b0, addrA},  32'h00);
    nextCycle();
    check("t6 first valid", {31'b0, validA}, 32'd1);
    check("t6 first pc",    {24'b0, pcA},    32'h00);
    check("t6 first instr", {16'b0, instrA}, 32'h1000);
    nextCycle();
    check("t6 second pc",    {24'b0, pcA},    32'h01);
    check("t6 second instr", {16'b0, instrA}, 32'h1001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
